fault_classifier_mc: RTL and testbench
======================================

Name: fault_classifier_mc

Overview:
Multi-phase, windowed successor to the single-shot peak classifier. Tracks per-phase absolute voltage/current peaks over a window of WINDOW accepted samples. At each window end it applies the frozen threshold rule per phase, and a persistence FSM confirms and latches the fault. Sits between the ADC sample front-end and the protection/relay controller.

Parameters:
NUM_PH, 3, phase count (1..7)
DW, 16, signed sample width
WINDOW, 64, accepted samples per evaluation window (>=2)
V_TH, 4853, voltage peak threshold (unsigned, DW-1 bits)
I_TH, 31396, current peak threshold (unsigned, DW-1 bits)
CONFIRM, 3, consecutive faulty windows required to trip (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
s_valid  in  1  sample strobe; one sample set per asserted cycle
v_in  in  NUM_PH*DW  packed signed phase voltages, phase 0 in LSBs
i_in  in  NUM_PH*DW  packed signed phase currents
fault_clr  in  1  clear request for the latched fault, one-cycle pulse
res_valid  out  1  one-cycle pulse per completed window
phase_mask  out  NUM_PH  per-phase fault flags of the last window
fault_type  out  3  latched fault code
fault_latched  out  1  high while state is TRIPPED

Behaviour:
- Reset: all outputs 0; peaks 0; window count 0; persistence count 0; state NORMAL.
- Absolute value saturates: -2^(DW-1) becomes 2^(DW-1)-1. Peak registers hold max(|x|) per phase and quantity. Cycles without s_valid do not change any sample path state.
- Window counter runs 0..WINDOW-1 on s_valid and wraps. On the last sample (count WINDOW-1 and s_valid):
  - Final peaks include that sample.
  - Per-phase flag = (Vpk > V_TH) && (Ipk > I_TH). Comparisons are strict; equality is not a fault.
  - phase_mask is registered and res_valid pulses on the next cycle (latency 1).
  - Peaks clear to 0 so the next window starts fresh.
- Window code = popcount(mask), saturated at 7: 0 NORMAL, 1 SLG, 2 LL, 3 LLL.
- FSM, evaluated only at window end:
  - NORMAL: mask != 0 and CONFIRM == 1 -> TRIPPED. mask != 0 otherwise -> PENDING, cnt = 1.
  - PENDING: mask != 0 -> cnt += 1, and cnt == CONFIRM -> TRIPPED. mask == 0 -> NORMAL, cnt = 0.
  - TRIPPED: fault_type = code of the confirming window, held; later windows do not change it. phase_mask keeps updating.
- fault_clr in TRIPPED or PENDING -> NORMAL, cnt = 0, fault_type = 0, next cycle. fault_clr in NORMAL has no effect.
- fault_clr coincident with a window end: the clear is applied first, then the window is evaluated from NORMAL.
- Reset mid-window discards partial peaks and the count. Reset has priority over all other events.

Optional Feature:
Macro PEAK_OUT_EN.
- Defined: adds outputs v_peak and i_peak (NUM_PH*DW each, unsigned magnitudes). These are the final window peaks, registered with phase_mask and valid when res_valid is high. Reset value 0.
- Undefined: ports absent, no extra registers.

Decomposition:
- Shared package fault_pkg holds fault code constants (NORMAL=0, SLG=1, LL=2, LLL=3), the FSM state enum, and the 3-bit fault code typedef.
- One natural sub-module, phase_peak_tracker: one per phase, instantiated NUM_PH times. It performs saturating abs, V/I peak registers, window-end clear, and threshold compare, and outputs the flag.

Test Plan:
- Window of 64 samples with all phases V=3000, I=32000 -> res_valid pulses, mask=000, fault_type=0, fault_latched=0.
- Phase 1 V=5000, I=-32000 for 3 consecutive windows -> mask=010 each window. TRIPPED after window 3, fault_type=1; after windows 1 and 2 fault_latched=0.
- Phases 0 and 2 faulty for 2 windows, then clean window -> back to NORMAL, no trip. A following 3 faulty windows with all phases -> fault_type=3.
- Boundary: V exactly 4853, I=31397 -> no fault. V=-32768 saturates to 32767 and counts as a fault.
- fault_clr on the same cycle as the third faulty window end after a prior trip -> state PENDING, cnt=1, fault_latched=0.
- rst asserted at sample 30 of a faulty window -> outputs 0; the next 64 clean samples give mask=000.

Source files
------------

// File: rtl/fault_pkg.sv
// Shared definitions for the multi-phase fault classifier: fault codes,
// persistence FSM states and the mask-to-code helper.
package fault_pkg;

    typedef logic [2:0] fault_code_t;

    localparam fault_code_t FC_NORMAL = 3'd0;
    localparam fault_code_t FC_SLG    = 3'd1;
    localparam fault_code_t FC_LL     = 3'd2;
    localparam fault_code_t FC_LLL    = 3'd3;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_PENDING = 2'd1,
        ST_TRIPPED = 2'd2
    } state_t;

    // Window code is the number of faulty phases, saturated to the 3-bit code.
    function automatic fault_code_t mask_to_code(input logic [7:0] m);
        int n;
        n = 0;
        for (int b = 0; b < 8; b++) n += int'(m[b]);
        if (n > 7) return 3'd7;
        return fault_code_t'(n);
    endfunction

endpackage

// File: rtl/phase_peak_tracker.sv
// Per-phase peak tracker: saturating |v|/|i|, running peaks over a window,
// clear at window end, and strict threshold compare on the final peaks.
// With PEAK_OUT_EN defined, the final peaks are also exported.
module phase_peak_tracker
    import fault_pkg::*;
#(
    parameter int DW   = 16,
    parameter int V_TH = 4853,
    parameter int I_TH = 31396
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic          win_end,
    input  logic [DW-1:0] v_in,
    input  logic [DW-1:0] i_in,
    output logic          flag
`ifdef PEAK_OUT_EN
    ,
    output logic [DW-2:0] v_pk,
    output logic [DW-2:0] i_pk
`endif
);

    localparam logic [DW-2:0] V_TH_W = (DW-1)'(V_TH);
    localparam logic [DW-2:0] I_TH_W = (DW-1)'(I_TH);

    logic [DW-2:0] vpk_q, vpk_d, ipk_q, ipk_d;
    logic [DW-1:0] v_mag, i_mag;
    logic [DW-2:0] v_abs, i_abs, v_max, i_max;

    // Two's-complement magnitude; only the most negative code sets the MSB,
    // and that one saturates to the largest positive magnitude.
    always_comb begin
        v_mag = v_in[DW-1] ? (~v_in + 1'b1) : v_in;
        i_mag = i_in[DW-1] ? (~i_in + 1'b1) : i_in;
        v_abs = v_mag[DW-1] ? '1 : v_mag[DW-2:0];
        i_abs = i_mag[DW-1] ? '1 : i_mag[DW-2:0];
        v_max = (v_abs > vpk_q) ? v_abs : vpk_q;
        i_max = (i_abs > ipk_q) ? i_abs : ipk_q;
        flag  = (v_max > V_TH_W) && (i_max > I_TH_W);
        vpk_d = vpk_q;
        ipk_d = ipk_q;
        if (s_valid) begin
            vpk_d = win_end ? '0 : v_max;
            ipk_d = win_end ? '0 : i_max;
        end
    end

`ifdef PEAK_OUT_EN
    assign v_pk = v_max;
    assign i_pk = i_max;
`endif

    // Peak registers; idle cycles hold them.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpk_q <= '0;
            ipk_q <= '0;
        end else begin
            vpk_q <= vpk_d;
            ipk_q <= ipk_d;
        end
    end

endmodule

// File: rtl/fault_classifier_mc.sv
// Multi-phase windowed fault classifier. Per-phase peak trackers feed a
// window-end mask; a persistence FSM confirms CONFIRM consecutive faulty
// windows before latching the fault code until fault_clr.
// Optional macro PEAK_OUT_EN adds v_peak/i_peak window peak outputs.
module fault_classifier_mc
    import fault_pkg::*;
#(
    parameter int NUM_PH  = 3,
    parameter int DW      = 16,
    parameter int WINDOW  = 64,
    parameter int V_TH    = 4853,
    parameter int I_TH    = 31396,
    parameter int CONFIRM = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    input  logic [NUM_PH*DW-1:0] v_in,
    input  logic [NUM_PH*DW-1:0] i_in,
    input  logic                 fault_clr,
    output logic                 res_valid,
    output logic [NUM_PH-1:0]    phase_mask,
    output logic [2:0]           fault_type,
    output logic                 fault_latched
`ifdef PEAK_OUT_EN
    ,
    output logic [NUM_PH*DW-1:0] v_peak,
    output logic [NUM_PH*DW-1:0] i_peak
`endif
);

    localparam int WW = $clog2(WINDOW);
    localparam int CW = $clog2(CONFIRM + 1);

    logic [WW-1:0]     wcnt_q, wcnt_d;
    logic              win_end;
    logic [NUM_PH-1:0] flags;
    logic [NUM_PH-1:0] mask_q, mask_d;
    logic              rv_q, rv_d;
    state_t            state_q, state_d;
    logic [CW-1:0]     pcnt_q, pcnt_d;
    fault_code_t       ftype_q, ftype_d;
    fault_code_t       win_code;

    assign win_end  = s_valid && (wcnt_q == WW'(WINDOW - 1));
    assign win_code = mask_to_code(8'(flags));

`ifdef PEAK_OUT_EN
    logic [NUM_PH-1:0][DW-2:0] vpk_fin, ipk_fin;
    logic [NUM_PH*DW-1:0]      vpo_q, vpo_d, ipo_q, ipo_d;
`endif

    for (genvar g = 0; g < NUM_PH; g++) begin : g_ph
        phase_peak_tracker #(
            .DW   (DW),
            .V_TH (V_TH),
            .I_TH (I_TH)
        ) u_trk (
            .clk     (clk),
            .rst     (rst),
            .s_valid (s_valid),
            .win_end (win_end),
            .v_in    (v_in[g*DW +: DW]),
            .i_in    (i_in[g*DW +: DW]),
            .flag    (flags[g])
`ifdef PEAK_OUT_EN
            ,
            .v_pk    (vpk_fin[g]),
            .i_pk    (ipk_fin[g])
`endif
        );
    end

    // Window counter, result mask and result strobe.
    always_comb begin
        wcnt_d = wcnt_q;
        if (s_valid) wcnt_d = win_end ? '0 : wcnt_q + 1'b1;
        mask_d = win_end ? flags : mask_q;
        rv_d   = win_end;
`ifdef PEAK_OUT_EN
        vpo_d = vpo_q;
        ipo_d = ipo_q;
        if (win_end) begin
            for (int p = 0; p < NUM_PH; p++) begin
                vpo_d[p*DW +: DW] = {1'b0, vpk_fin[p]};
                ipo_d[p*DW +: DW] = {1'b0, ipk_fin[p]};
            end
        end
`endif
    end

    // Persistence FSM: a clear lands first, then the window is judged from
    // the post-clear state.
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        ftype_d = ftype_q;
        if (fault_clr && state_q != ST_NORMAL) begin
            state_d = ST_NORMAL;
            pcnt_d  = '0;
            ftype_d = FC_NORMAL;
        end
        if (win_end) begin
            case (state_d)
                ST_NORMAL: begin
                    if (|flags) begin
                        if (CONFIRM == 1) begin
                            state_d = ST_TRIPPED;
                            ftype_d = win_code;
                        end else begin
                            state_d = ST_PENDING;
                            pcnt_d  = CW'(1);
                        end
                    end
                end
                ST_PENDING: begin
                    if (|flags) begin
                        pcnt_d = pcnt_q + CW'(1);
                        if (pcnt_d == CW'(CONFIRM)) begin
                            state_d = ST_TRIPPED;
                            ftype_d = win_code;
                        end
                    end else begin
                        state_d = ST_NORMAL;
                        pcnt_d  = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q  <= '0;
            mask_q  <= '0;
            rv_q    <= 1'b0;
            state_q <= ST_NORMAL;
            pcnt_q  <= '0;
            ftype_q <= FC_NORMAL;
`ifdef PEAK_OUT_EN
            vpo_q   <= '0;
            ipo_q   <= '0;
`endif
        end else begin
            wcnt_q  <= wcnt_d;
            mask_q  <= mask_d;
            rv_q    <= rv_d;
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            ftype_q <= ftype_d;
`ifdef PEAK_OUT_EN
            vpo_q   <= vpo_d;
            ipo_q   <= ipo_d;
`endif
        end
    end

    assign res_valid     = rv_q;
    assign phase_mask    = mask_q;
    assign fault_type    = ftype_q;
    assign fault_latched = (state_q == ST_TRIPPED);
`ifdef PEAK_OUT_EN
    assign v_peak = vpo_q;
    assign i_peak = ipo_q;
`endif

endmodule

// File: tb/tb_fault_classifier_mc.sv
// Directed bench for fault_classifier_mc (3 phases, 64-sample window, CONFIRM=3).
module tb_fault_classifier_mc;

    localparam int NP = 3;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             s_valid;
    logic [NP*DW-1:0] v_in, i_in;
    logic             fault_clr;
    logic             res_valid;
    logic [NP-1:0]    phase_mask;
    logic [2:0]       fault_type;
    logic             fault_latched;
`ifdef PEAK_OUT_EN
    logic [NP*DW-1:0] v_peak, i_peak;
`endif

    int tests = 0;
    int fails = 0;
    int early = 0;

    always #5 clk = ~clk;

    fault_classifier_mc dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .v_in          (v_in),
        .i_in          (i_in),
        .fault_clr     (fault_clr),
        .res_valid     (res_valid),
        .phase_mask    (phase_mask),
        .fault_type    (fault_type),
        .fault_latched (fault_latched)
`ifdef PEAK_OUT_EN
        ,
        .v_peak        (v_peak),
        .i_peak        (i_peak)
`endif
    );

    function automatic logic [NP*DW-1:0] pk3(input int a0, input int a1, input int a2);
        return {16'(a2), 16'(a1), 16'(a0)};
    endfunction

    // Drives a full window of identical samples; leaves the bench just after
    // the result cycle's negedge. Counts res_valid seen before the window end.
    task automatic run_window(input logic [NP*DW-1:0] v, input logic [NP*DW-1:0] i,
                              input bit clr_last, input int n = 64);
        early = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (res_valid) early++;
            s_valid   = 1'b1;
            v_in      = v;
            i_in      = i;
            fault_clr = clr_last && (k == n - 1);
        end
        @(negedge clk);
        s_valid   = 1'b0;
        fault_clr = 1'b0;
    endtask

    task automatic check_win(input string name, input logic [NP-1:0] m,
                             input logic [2:0] ft, input logic fl);
        tests++;
        if (res_valid !== 1'b1 || phase_mask !== m || fault_type !== ft || fault_latched !== fl) begin
            fails++;
            $display("FAIL %s: got rv=%b mask=%b ft=%0d fl=%b, want rv=1 mask=%b ft=%0d fl=%b",
                     name, res_valid, phase_mask, fault_type, fault_latched, m, ft, fl);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; fault_clr = 1'b0; v_in = '0; i_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tests++;
        if (res_valid !== 1'b0 || phase_mask !== 3'b000 || fault_type !== 3'd0 || fault_latched !== 1'b0) begin
            fails++;
            $display("FAIL reset: rv=%b mask=%b ft=%0d fl=%b, want all 0",
                     res_valid, phase_mask, fault_type, fault_latched);
        end
    endtask

    task automatic test_clean();
        run_window(pk3(3000, 3000, 3000), pk3(32000, 32000, 32000), 1'b0);
        check_win("clean_window", 3'b000, 3'd0, 1'b0);
        tests++;
        if (early !== 0) begin
            fails++;
            $display("FAIL clean_early_rv: got %0d early pulses, want 0", early);
        end
`ifdef PEAK_OUT_EN
        tests++;
        if (v_peak !== pk3(3000, 3000, 3000) || i_peak !== pk3(32000, 32000, 32000)) begin
            fails++;
            $display("FAIL peak_out: v=%h i=%h", v_peak, i_peak);
        end
`endif
        @(negedge clk);
        tests++;
        if (res_valid !== 1'b0) begin
            fails++;
            $display("FAIL rv_one_cycle: got %b want 0", res_valid);
        end
    endtask

    task automatic test_slg_trip();
        for (int w = 0; w < 3; w++) begin
            run_window(pk3(3000, 5000, 3000), pk3(32000, -32000, 32000), 1'b0);
            if (w < 2) check_win($sformatf("slg_win%0d", w + 1), 3'b010, 3'd0, 1'b0);
            else       check_win("slg_trip", 3'b010, 3'd1, 1'b1);
        end
        pulse_clr();
        tests++;
        if (fault_latched !== 1'b0 || fault_type !== 3'd0) begin
            fails++;
            $display("FAIL clr_tripped: fl=%b ft=%0d, want 0 0", fault_latched, fault_type);
        end
    endtask

    task automatic test_recover_then_lll();
        run_window(pk3(6000, 0, 6000), pk3(32000, 0, 32000), 1'b0);
        check_win("ll_win1", 3'b101, 3'd0, 1'b0);
        run_window(pk3(6000, 0, 6000), pk3(32000, 0, 32000), 1'b0);
        check_win("ll_win2", 3'b101, 3'd0, 1'b0);
        run_window(pk3(100, 100, 100), pk3(100, 100, 100), 1'b0);
        check_win("recover_clean", 3'b000, 3'd0, 1'b0);
        for (int w = 0; w < 3; w++) begin
            run_window(pk3(6000, -6000, 6000), pk3(-32000, 32000, 32000), 1'b0);
            if (w < 2) check_win($sformatf("lll_win%0d", w + 1), 3'b111, 3'd0, 1'b0);
            else       check_win("lll_trip", 3'b111, 3'd3, 1'b1);
        end
    endtask

    task automatic test_clr_coincident();
        // Still tripped with code 3; later windows must not alter the code.
        run_window(pk3(0, 5000, 0), pk3(0, 32000, 0), 1'b0);
        check_win("tripped_hold1", 3'b010, 3'd3, 1'b1);
        run_window(pk3(0, 5000, 0), pk3(0, 32000, 0), 1'b0);
        check_win("tripped_hold2", 3'b010, 3'd3, 1'b1);
        run_window(pk3(0, 5000, 0), pk3(0, 32000, 0), 1'b1);
        check_win("clr_at_win_end", 3'b010, 3'd0, 1'b0);
        // Pending count must restart at 1: one more window stays pending,
        // the next one trips.
        run_window(pk3(0, 5000, 0), pk3(0, 32000, 0), 1'b0);
        check_win("after_clr_cnt2", 3'b010, 3'd0, 1'b0);
        run_window(pk3(0, 5000, 0), pk3(0, 32000, 0), 1'b0);
        check_win("after_clr_trip", 3'b010, 3'd1, 1'b1);
        pulse_clr();
        tests++;
        if (fault_latched !== 1'b0) begin
            fails++;
            $display("FAIL clr2: fl=%b want 0", fault_latched);
        end
    endtask

    task automatic test_boundary();
        run_window(pk3(4853, 0, 0), pk3(31397, 0, 0), 1'b0);
        check_win("v_equal_th", 3'b000, 3'd0, 1'b0);
        run_window(pk3(5000, 0, 0), pk3(31396, 0, 0), 1'b0);
        check_win("i_equal_th", 3'b000, 3'd0, 1'b0);
        run_window(pk3(-32768, 0, 0), pk3(31397, 0, 0), 1'b0);
        check_win("v_min_sat", 3'b001, 3'd0, 1'b0);
`ifdef PEAK_OUT_EN
        tests++;
        if (v_peak !== pk3(32767, 0, 0)) begin
            fails++;
            $display("FAIL peak_sat: v=%h", v_peak);
        end
`endif
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            s_valid = 1'b1;
            v_in    = pk3(9000, 9000, 9000);
            i_in    = pk3(32000, 32000, 32000);
        end
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (res_valid !== 1'b0 || phase_mask !== 3'b000 || fault_type !== 3'd0 || fault_latched !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: rv=%b mask=%b ft=%0d fl=%b, want all 0",
                     res_valid, phase_mask, fault_type, fault_latched);
        end
        run_window(pk3(1000, 1000, 1000), pk3(1000, 1000, 1000), 1'b0);
        check_win("post_reset_clean", 3'b000, 3'd0, 1'b0);
        tests++;
        if (early !== 0) begin
            fails++;
            $display("FAIL post_reset_early_rv: got %0d early pulses, want 0", early);
        end
        // The pre-reset pending count must be gone: two faulty windows
        // cannot trip.
        run_window(pk3(9000, 0, 0), pk3(32000, 0, 0), 1'b0);
        run_window(pk3(9000, 0, 0), pk3(32000, 0, 0), 1'b0);
        check_win("post_reset_no_trip", 3'b001, 3'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_slg_trip();
        test_recover_then_lll();
        test_clr_coincident();
        test_boundary();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
